// File: rtl/bp_me_pkg.sv
// Shared types for the memory-end stream blocks: message header layout,
// default widths and the stream arbiter state encoding.
package bp_me_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int lce_id_width_gp    = 8;
    localparam int lce_assoc_gp       = 8;
    localparam int dword_width_gp     = 64;
    localparam int cce_block_width_gp = 512;

    typedef struct packed {
        logic [3:0]                      msg_type;
        logic [3:0]                      subop;
        logic [paddr_width_gp-1:0]       addr;
        logic [2:0]                      size;
        logic [lce_id_width_gp-1:0]      lce_id;
        logic [$clog2(lce_assoc_gp)-1:0] way_id;
    } bp_bedrock_xce_mem_msg_header_s;

    localparam int xce_mem_msg_header_width_gp = $bits(bp_bedrock_xce_mem_msg_header_s);

    typedef enum logic {
        e_idle = 1'b0,
        e_lock = 1'b1
    } bp_me_stream_arb_state_e;

endpackage

// File: rtl/bp_me_rr_pick.sv
// Rotate-priority picker: first set bit of v_i at or above start_i, wrapping
// past the top entry back to 0. Purely combinational.
module bp_me_rr_pick
#(
    parameter int num_p    = 2,
    parameter int lg_num_p = $clog2(num_p)
)(
    input  logic [num_p-1:0]    v_i,
    input  logic [lg_num_p-1:0] start_i,
    output logic [num_p-1:0]    grant_oh_o,
    output logic [lg_num_p-1:0] grant_id_o,
    output logic                v_o
);

    logic [lg_num_p:0]   idx_w;
    logic [lg_num_p-1:0] idx;

    // Scan upward from start_i; the extra bit in idx_w handles the wrap for
    // non-power-of-two counts. With nothing valid the index rests on start_i.
    always_comb begin
        grant_oh_o = '0;
        grant_id_o = start_i;
        v_o        = 1'b0;
        idx_w      = '0;
        idx        = '0;
        for (int i = 0; i < num_p; i++) begin
            idx_w = {1'b0, start_i} + (lg_num_p+1)'(i);
            if (idx_w >= (lg_num_p+1)'(num_p))
                idx_w = idx_w - (lg_num_p+1)'(num_p);
            idx = idx_w[lg_num_p-1:0];
            if (!v_o && v_i[idx]) begin
                v_o             = 1'b1;
                grant_id_o      = idx;
                grant_oh_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_stream_arb.sv
// Message-granular round-robin merge of several BedRock streams onto one.
// A grant, once a beat has been offered, is held until that requester's last
// beat is accepted, so messages never interleave and a stalled beat is stable.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   e_idle | no grant held; rotate-pick from rr_ptr_r each cycle
//   e_lock | only lock_id_r is passed until its last beat is accepted
module bp_me_stream_arb
    import bp_me_pkg::*;
#(
    parameter  int stream_data_width_p         = dword_width_gp,
    parameter  int block_width_p               = cce_block_width_gp,
    parameter  int num_inputs_p                = 2,
    localparam int lg_inputs_lp                = $clog2(num_inputs_p),
    localparam int xce_mem_msg_header_width_lp = xce_mem_msg_header_width_gp
)(
    input  logic                                                 clk_i,
    input  logic                                                 reset_n_i,
    input  logic [num_inputs_p*xce_mem_msg_header_width_lp-1:0]  in_header_i,
    input  logic [num_inputs_p*stream_data_width_p-1:0]          in_data_i,
    input  logic [num_inputs_p-1:0]                              in_v_i,
    input  logic [num_inputs_p-1:0]                              in_last_i,
    output logic [num_inputs_p-1:0]                              in_ready_and_o,
    output logic [xce_mem_msg_header_width_lp-1:0]               out_header_o,
    output logic [stream_data_width_p-1:0]                       out_data_o,
    output logic                                                 out_v_o,
    output logic                                                 out_last_o,
    input  logic                                                 out_ready_and_i,
    output logic [lg_inputs_lp-1:0]                              grant_id_o,
    output logic                                                 locked_o,
    output logic                                                 err_o
);

    localparam int hw_lp           = xce_mem_msg_header_width_lp;
    localparam int dw_lp           = stream_data_width_p;
    localparam int stream_words_lp = block_width_p / stream_data_width_p;
    localparam int cnt_w_lp        = $clog2(stream_words_lp) + 1;

    localparam logic [lg_inputs_lp-1:0] last_id_lp = lg_inputs_lp'(num_inputs_p - 1);
    localparam logic [cnt_w_lp-1:0]     words_lp   = cnt_w_lp'(stream_words_lp);

    bp_me_stream_arb_state_e state_r, state_n;

    logic [lg_inputs_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [lg_inputs_lp-1:0] lock_id_r, lock_id_n;
    logic [cnt_w_lp-1:0]     beat_cnt_r, beat_cnt_n;
    logic                    err_r, err_n;

    logic [num_inputs_p-1:0] pick_oh;
    logic [lg_inputs_lp-1:0] pick_id;
    logic                    pick_v;
    logic [num_inputs_p-1:0] sel_oh;
    logic [lg_inputs_lp-1:0] grant_id;
    logic                    acc;
    logic                    acc_last;

    function automatic logic [lg_inputs_lp-1:0] wrap_inc(input logic [lg_inputs_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + lg_inputs_lp'(1);
    endfunction

    bp_me_rr_pick #(
        .num_p (num_inputs_p)
    ) pick (
        .v_i        (in_v_i),
        .start_i    (rr_ptr_r),
        .grant_oh_o (pick_oh),
        .grant_id_o (pick_id),
        .v_o        (pick_v)
    );

    // Select source: the held lock, or the fresh rotate-pick while idle.
    always_comb begin
        sel_oh   = pick_oh;
        grant_id = pick_id;
        out_v_o  = pick_v;
        if (state_r == e_lock) begin
            grant_id = lock_id_r;
            out_v_o  = in_v_i[lock_id_r];
            for (int i = 0; i < num_inputs_p; i++)
                sel_oh[i] = (lock_id_r == lg_inputs_lp'(i));
        end
    end

    // One-hot AND-OR mux of the selected input onto the output stream.
    always_comb begin
        out_header_o = '0;
        out_data_o   = '0;
        out_last_o   = 1'b0;
        for (int i = 0; i < num_inputs_p; i++) begin
            if (sel_oh[i]) begin
                out_header_o = out_header_o | in_header_i[i*hw_lp +: hw_lp];
                out_data_o   = out_data_o   | in_data_i[i*dw_lp +: dw_lp];
                out_last_o   = out_last_o   | in_last_i[i];
            end
        end
    end

    // Gating with out_v_o keeps all ready bits low when nothing is offered.
    assign in_ready_and_o = sel_oh & {num_inputs_p{out_ready_and_i & out_v_o}};
    assign acc            = out_v_o & out_ready_and_i;
    assign acc_last       = acc & out_last_o;

    // Next-state: lock on any offered beat that does not finish its message.
    always_comb begin
        state_n   = state_r;
        rr_ptr_n  = rr_ptr_r;
        lock_id_n = lock_id_r;
        case (state_r)
            e_idle: begin
                if (acc_last) begin
                    rr_ptr_n = wrap_inc(grant_id);
                end else if (out_v_o) begin
                    state_n   = e_lock;
                    lock_id_n = grant_id;
                end
            end
            e_lock: begin
                if (acc_last) begin
                    state_n  = e_idle;
                    rr_ptr_n = wrap_inc(lock_id_r);
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // Beat counter saturates at the block limit; overrunning it flags err.
    always_comb begin
        beat_cnt_n = beat_cnt_r;
        err_n      = err_r;
        if (acc_last) begin
            beat_cnt_n = '0;
        end else if (acc) begin
            if (beat_cnt_r != words_lp)
                beat_cnt_n = beat_cnt_r + cnt_w_lp'(1);
            if (beat_cnt_r >= words_lp - cnt_w_lp'(1))
                err_n = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_r <= e_idle;
        else
            state_r <= state_n;
    end

    // Pointer, lock index, beat counter and sticky error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_r   <= '0;
            lock_id_r  <= '0;
            beat_cnt_r <= '0;
            err_r      <= 1'b0;
        end else begin
            rr_ptr_r   <= rr_ptr_n;
            lock_id_r  <= lock_id_n;
            beat_cnt_r <= beat_cnt_n;
            err_r      <= err_n;
        end
    end

    assign grant_id_o = grant_id;
    assign locked_o   = (state_r == e_lock);
    assign err_o      = err_r;

endmodule

// File: doc/bp_me_stream_arb.md
# bp_me_stream_arb

Message-granular round-robin arbiter that merges `num_inputs_p` inbound BedRock Stream channels onto one BedRock Stream output. It typically sits in front of `bp_me_stream_pump_in` or a memory-side stream sink. Once a beat from one requester has been offered, the grant is locked until that requester's `last` beat is accepted. Multi-beat messages are therefore never interleaved, and an offered beat never changes while it is stalled.

## Interface
- `bp_params_p`, default `e_bp_default_cfg`: proc params; supplies `paddr_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `stream_data_width_p`, default `dword_width_gp`: data beat width.
- `block_width_p`, default `cce_block_width_p`: maximum message payload; beat limit `stream_words_lp = block_width_p/stream_data_width_p`.
- `num_inputs_p`, default 2: requester count, ≥2; `lg_inputs_lp = clog2(num_inputs_p)`.
- `clk_i`, input, 1: the block's only clock.
- `reset_n_i`, input, 1: reset, asynchronous and active-low.
- `in_header_i`, input, `num_inputs_p*xce_mem_msg_header_width_lp`: per-input headers.
- `in_data_i`, input, `num_inputs_p*stream_data_width_p`: per-input data.
- `in_v_i`, input, `num_inputs_p`: per-input valid.
- `in_last_i`, input, `num_inputs_p`: per-input last-beat flag.
- `in_ready_and_o`, output, `num_inputs_p`: per-input ready.
- `out_header_o`, output, `xce_mem_msg_header_width_lp`: granted header.
- `out_data_o`, output, `stream_data_width_p`: granted data.
- `out_v_o`, output, 1: granted valid.
- `out_last_o`, output, 1: granted last.
- `out_ready_and_i`, input, 1: downstream ready.
- `grant_id_o`, output, `lg_inputs_lp`: index currently selected; meaningful when `out_v_o`.
- `locked_o`, output, 1: an arbitration decision is held.
- `err_o`, output, 1: sticky protocol error.

## Operation
- FSM states:
  - `e_idle`: no grant held. Pick the first valid input at or after `rr_ptr_r`, scanning upward with wrap.
  - `e_lock`: `lock_id_r` is the only input passed.
- Datapath: `out_*` equals `in_*[grant]`. `in_ready_and_o[grant]` equals `out_ready_and_i`; all other ready bits are 0. `out_v_o` is 0 when no input is granted.
- Accept event `acc = out_v_o & out_ready_and_i`.
- Transitions out of `e_idle`:
  - `out_v_o & ~(acc & out_last_o)` → `e_lock`, with `lock_id_r <= grant`. This covers a stalled first beat as well as an accepted non-last beat.
  - `acc & out_last_o` (single-beat message) → stay in `e_idle`, `rr_ptr_r <= grant+1` modulo `num_inputs_p`.
- Transitions out of `e_lock`:
  - `acc & out_last_o` → `e_idle`, `rr_ptr_r <= lock_id_r+1` modulo `num_inputs_p`.
- Locked input drops `v` mid-message: stay in `e_lock`, hold `out_v_o=0`, no rearbitration.
- Beat counter `beat_cnt_r`:
  - Width `clog2(stream_words_lp)+1`.
  - Increments on each non-last `acc`; cleared on `acc & out_last_o`.
  - Reaching `stream_words_lp` without a last beat sets `err_o` (sticky until reset). The counter saturates and the lock is retained.
- `locked_o = (state_r==e_lock)`.

## Timing
- Zero-cycle path from `in_v_i`/`in_*` to `out_*`, and from `out_ready_and_i` to `in_ready_and_o`. No storage in the datapath.
- Grant, pointer, counter and error update on the rising edge of `clk_i` only.
- Reset (`reset_n_i` low, effective immediately):
  - `state_r=e_idle`, `rr_ptr_r=0`, `lock_id_r=0`, `beat_cnt_r=0`, `err_o=0`, `locked_o=0`.
  - With no valid inputs, `out_v_o=0` and `in_ready_and_o=0`.
- Reset asserted mid-message discards the lock. Upstream is expected to be reset together with this block.
- Stability: while `out_v_o & ~out_ready_and_i`, `grant_id_o` and `out_*` are unchanged next cycle, provided the granted input holds its beat.
- Throughput: one beat per cycle. Back-to-back messages from different inputs incur no bubble.
- `num_inputs_p` not a power of two: pointer wraps from `num_inputs_p-1` to 0.

## Structure
- Headers use the `bp_bedrock_xce_mem_msg_header_s` typedef via the shared `declare_bp_bedrock_mem_if` macro.
- The state enum `bp_me_stream_arb_state_e` (`e_idle`, `e_lock`) belongs in `bp_me_pkg`.
- One sub-module, `bp_me_rr_pick`: combinational rotate-priority one-hot/index picker. Inputs: `v` vector and start pointer.
- The top level holds the FSM, registers, counter, and mux (`bsg_mux_one_hot`).

## Test plan
- Single-beat messages, inputs 0 and 1 both valid every cycle, `out_ready_and_i=1` → grants alternate 0,1,0,1; `locked_o` stays 0.
- Input 0 sends a 4-beat message while input 1 is valid throughout → four beats from input 0 with `last` on beat 4; `in_ready_and_o[1]=0` during them; input 1 is granted the next cycle.
- Input 1 offered alone with `out_ready_and_i=0` for 3 cycles, then input 0 rises and priority favours 0 → output stays on input 1 until accepted; `locked_o=1` during the stall.
- Locked input 0 drops `v` for 2 cycles mid-message while input 1 is valid → `out_v_o=0` for 2 cycles, then input 0 resumes; input 1 is never passed.
- `block_width_p=512`, `stream_data_width_p=64`, input sends 8 beats with no `last` → `err_o=1` after the 8th accept and stays 1; lock retained.
- Assert `reset_n_i` asynchronously mid-lock → `locked_o`, `err_o`, `rr_ptr_r` clear immediately; the first message after reset grants input 0.
